// File: rtl/ls_unit_pkg.sv
// Shared constants for the load/store stage: datapath widths, opcodes,
// funct3 codes and the access FSM state encoding.
package ls_unit_pkg;

    localparam int XLEN     = 64;
    localparam int INST_LEN = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        LS_IDLE = 2'd0,
        LS_REQ  = 2'd1,
        LS_WAIT = 2'd2,
        LS_DONE = 2'd3
    } ls_state_e;

endpackage

// File: rtl/ls_unit_if.sv
// Data-memory request/response port between the load/store stage (master)
// and the data memory (slave).
interface ls_unit_if;
    import ls_unit_pkg::*;

    logic            mem_req_valid_o;
    logic            mem_req_ready_i;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [7:0]      mem_wmask_o;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport master (
        output mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_req_ready_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_req_ready_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/ls_align.sv
// Combinational lane logic: misalignment check, store byte-lane placement,
// and load extraction with sign/zero extension.
module ls_align
    import ls_unit_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      lane,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rdata,
    output logic            misalign,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data
);

    logic [1:0]      sz;
    logic [7:0]      base_mask;
    logic [XLEN-1:0] shifted;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input logic [1:0]      size,
                                               input logic            is_signed);
        case (size)
            2'd0:    extend = is_signed ? {{(XLEN-8){v[7]}}, v[7:0]}
                                        : {{(XLEN-8){1'b0}}, v[7:0]};
            2'd1:    extend = is_signed ? {{(XLEN-16){v[15]}}, v[15:0]}
                                        : {{(XLEN-16){1'b0}}, v[15:0]};
            2'd2:    extend = is_signed ? {{(XLEN-32){v[31]}}, v[31:0]}
                                        : {{(XLEN-32){1'b0}}, v[31:0]};
            default: extend = v;
        endcase
    endfunction

    // funct3[1:0] is log2 of the access size for every load/store encoding
    assign sz = funct3[1:0];

    always_comb begin
        misalign  = 1'b0;
        base_mask = 8'h01;
        case (sz)
            2'd0: begin misalign = 1'b0;         base_mask = 8'h01; end
            2'd1: begin misalign = lane[0];      base_mask = 8'h03; end
            2'd2: begin misalign = |lane[1:0];   base_mask = 8'h0F; end
            default: begin misalign = |lane;     base_mask = 8'hFF; end
        endcase
    end

    assign wmask   = base_mask << lane;
    assign wdata   = rs2 << {lane, 3'b000};
    assign shifted = rdata >> {lane, 3'b000};
    assign ld_data = extend(shifted, sz, ~funct3[2]);

endmodule

// File: rtl/ls_unit.sv
// Load/store pipeline stage: decodes memory ops, sequences one data-memory
// transaction per access and stalls upstream while it is in flight.
module ls_unit
    import ls_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [XLEN-1:0]     rs2_i,
    input  logic [XLEN-1:0]     alures_i,
    input  logic [INST_LEN-1:0] instr_i,
    input  logic                wben_i,
    input  logic                trap_i,
    ls_unit_if.master           mem,
    output logic                ls_stall_o,
    output logic                misalign_o,
    output logic [XLEN-1:0]     wb_pc_o,
    output logic [XLEN-1:0]     wb_data_o,
    output logic [INST_LEN-1:0] wb_instr_o,
    output logic                wb_wben_o,
    output logic                wb_trap_o
);

    ls_state_e       state_q, state_d;
    logic [XLEN-1:0] ld_data_q;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wdata;
    logic [7:0]      wmask;
    logic            lane_mis;
    logic            is_load, is_store, is_mem, go;
    logic            req_valid, stall, capture;
    logic [2:0]      funct3;

    assign funct3   = instr_i[14:12];
    assign is_load  = (instr_i[6:0] == OPC_LOAD)  && (funct3 != 3'b111);
    assign is_store = (instr_i[6:0] == OPC_STORE) && !funct3[2];
    assign is_mem   = is_load || is_store;

    ls_align u_align (
        .funct3   (funct3),
        .lane     (alures_i[2:0]),
        .rs2      (rs2_i),
        .rdata    (mem.mem_rdata_i),
        .misalign (lane_mis),
        .wmask    (wmask),
        .wdata    (wdata),
        .ld_data  (ld_data)
    );

    assign misalign_o = is_mem && lane_mis;
    assign go         = is_mem && !lane_mis && !trap_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= LS_IDLE;
            ld_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) ld_data_q <= ld_data;
        end
    end

    // Response is only honoured in WAIT; stray rvalid elsewhere is dropped
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        stall     = 1'b0;
        capture   = 1'b0;
        case (state_q)
            LS_IDLE: begin
                if (go) begin
                    req_valid = 1'b1;
                    stall     = 1'b1;
                    if (mem.mem_req_ready_i) state_d = is_load ? LS_WAIT : LS_DONE;
                    else                     state_d = LS_REQ;
                end
            end
            LS_REQ: begin
                req_valid = 1'b1;
                stall     = 1'b1;
                if (mem.mem_req_ready_i) state_d = is_load ? LS_WAIT : LS_DONE;
            end
            LS_WAIT: begin
                stall = 1'b1;
                if (mem.mem_rvalid_i) begin
                    capture = 1'b1;
                    state_d = LS_DONE;
                end
            end
            LS_DONE: state_d = LS_IDLE;
            default: state_d = LS_IDLE;
        endcase
    end

    assign mem.mem_req_valid_o = req_valid;
    assign mem.mem_we_o        = is_store;
    assign mem.mem_addr_o      = {alures_i[XLEN-1:3], 3'b000};
    assign mem.mem_wdata_o     = is_store ? wdata : '0;
    assign mem.mem_wmask_o     = is_store ? wmask : 8'h00;

    assign ls_stall_o = stall;
    assign wb_pc_o    = pc_i;
    assign wb_instr_o = instr_i;
    assign wb_wben_o  = wben_i && !misalign_o;
    assign wb_trap_o  = trap_i || misalign_o;
    assign wb_data_o  = (state_q == LS_DONE && is_load) ? ld_data_q : alures_i;

endmodule
